uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//   8N1 UART receiver. It is the consumer of the serial line driven by the SPI->UART transmit path.
//   - Oversamples the asynchronous RX line at the baud divider rate.
//   - Validates the start and stop bits, assembles one byte LSB-first and presents it with a sticky new_data flag.
//   - new_data holds until acknowledged by check_rxd.
//   - Feeds the LED/FND display stage; baud rate is selectable at runtime, as on the TX side.
// PARAMETERS
//   T_DIV_BIT     13        width of the divider counter
//   T_DIV_0       5207      bit period - 1 in clk cycles, baudrate=0 (9,600 @ 50 MHz)
//   T_DIV_HALF_0  2603      half bit period - 1, baudrate=0
//   T_DIV_1       2603      bit period - 1, baudrate=1 (19,200 @ 50 MHz)
//   T_DIV_HALF_1  1301      half bit period - 1, baudrate=1
// PORTS
//   clk         in   1  system clock; all logic on posedge
//   rst         in   1  synchronous, active-high reset
//   uart_rxd_n  in   1  async serial line, idle high, start bit low
//   baudrate    in   1  divider select (0: T_DIV_0/_HALF_0, 1: T_DIV_1/_HALF_1)
//   check_rxd   in   1  one-cycle acknowledge; clears new_data and overrun
//   data        out  8  last good received byte
//   new_data    out  1  sticky: a good byte is waiting
//   frame_err   out  1  last frame had stop bit = 0
//   overrun     out  1  a byte completed while new_data was still 1
//   busy        out  1  1 whenever state != IDLE
// BEHAVIOUR
//   Input path
//   - uart_rxd_n passes through a 2-FF synchronizer (reset value 1) giving rxd_s, plus a prev register (reset 1).
//   - Start detect = rxd_s==0 && prev==1.
//   Reset
//   - data=0, new_data=0, frame_err=0, overrun=0, busy=0, state=IDLE, counters=0.
//   - Asserting rst mid-frame aborts the frame with no output update.
//   Divider select
//   - baudrate is latched into div_sel on start detect only.
//   - Changes to baudrate mid-frame are ignored until the next frame.
//   FSM
//   - IDLE: on start detect -> START, cnt_div=0.
//   - START: count to HALF(div_sel).
//     - At HALF, if rxd_s==0 -> DATA, cnt_div=0, cnt_bit=0.
//     - Otherwise (glitch) -> IDLE, no flag change.
//   - DATA: count to DIV(div_sel).
//     - At DIV: shift = {rxd_s, shift[7:1]}, cnt_bit++, cnt_div=0.
//     - After the 8th sample -> STOP.
//   - STOP: count to DIV. At DIV, sample rxd_s:
//     - If 1: data<=shift, new_data<=1, frame_err<=0, and overrun<=1 if new_data was 1 and check_rxd is 0.
//     - If 0: frame_err<=1; data, new_data and overrun unchanged.
//     - Either way -> IDLE the same cycle. Re-arming at mid-stop allows back-to-back frames.
//   Acknowledge
//   - check_rxd=1 clears new_data and overrun on the next edge.
//   - If check_rxd coincides with a good-stop completion: new_data stays 1, data updates, overrun is not set.
//   Latency
//   - new_data rises (HALF+1) + 9*(DIV+1) + 3 cycles after the start edge at the pin (2 sync + 1 detect), +/-1 for async phase.
//   Widths
//   - cnt_div is T_DIV_BIT wide, compared with == only; it never wraps past DIV.
//   - cnt_bit is 4 bits.
// TESTING  (sim params: T_DIV_BIT=4, T_DIV_0=15, HALF_0=7, T_DIV_1=7, HALF_1=3)
//   1. baudrate=0, send 0xC5 at 16 clk/bit -> data=8'hC5, new_data=1, frame_err=0; pulse check_rxd -> new_data=0 next cycle.
//   2. baudrate=1, send 0xA3 at 8 clk/bit -> data=8'hA3, new_data=1; toggling baudrate mid-frame still yields 0xA3.
//   3. baudrate=0, line low for 4 clk then high -> busy returns 0 after 8 clk in START; new_data and data unchanged.
//   4. Send 0x3C with stop bit=0 -> frame_err=1, new_data=0, data keeps the previous 0xC5; next good 0x55 clears frame_err.
//   5. Back-to-back 0x11, 0x22 with no ack -> data=8'h22, new_data=1, overrun=1; check_rxd -> both 0.
//   6. rst pulsed during DATA bit 4 -> all outputs 0, busy=0; the following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with runtime baud select, sticky new-data flag and frame/overrun status
module uart_rx_byte #(
    parameter int T_DIV_BIT    = 13,
    parameter int T_DIV_0      = 5207,
    parameter int T_DIV_HALF_0 = 2603,
    parameter int T_DIV_1      = 2603,
    parameter int T_DIV_HALF_1 = 1301
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd_n_i,
    input  logic       baudrate_i,
    input  logic       check_rxd_i,
    output logic [7:0] data_o,
    output logic       new_data_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    localparam logic [T_DIV_BIT-1:0] DIV0  = T_DIV_BIT'(T_DIV_0);
    localparam logic [T_DIV_BIT-1:0] HALF0 = T_DIV_BIT'(T_DIV_HALF_0);
    localparam logic [T_DIV_BIT-1:0] DIV1  = T_DIV_BIT'(T_DIV_1);
    localparam logic [T_DIV_BIT-1:0] HALF1 = T_DIV_BIT'(T_DIV_HALF_1);
    state_e               state_q;
    logic                 rx_meta_q, rxd_s_q, prev_q, div_sel_q;
    logic [T_DIV_BIT-1:0] cnt_div_q, div_lim, half_lim;
    logic [3:0]           cnt_bit_q;
    logic [7:0]           shift_q, shift_d, data_q;
    logic                 new_data_q, frame_err_q, overrun_q, busy_q, start_det;
    always_comb begin
        start_det = !rxd_s_q && prev_q;
        div_lim   = div_sel_q ? DIV1 : DIV0;
        half_lim  = div_sel_q ? HALF1 : HALF0;
        shift_d   = {rxd_s_q, shift_q[7:1]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rxd_s_q     <= 1'b1;
            prev_q      <= 1'b1;
            div_sel_q   <= 1'b0;
            cnt_div_q   <= '0;
            cnt_bit_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q <= uart_rxd_n_i;
            rxd_s_q   <= rx_meta_q;
            prev_q    <= rxd_s_q;
            if (check_rxd_i) begin
                new_data_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            case (state_q)
                IDLE: if (start_det) begin
                    state_q   <= START;
                    busy_q    <= 1'b1;
                    cnt_div_q <= '0;
                    div_sel_q <= baudrate_i;
                end
                START: if (cnt_div_q == half_lim) begin
                    state_q   <= rxd_s_q ? IDLE : DATA;
                    busy_q    <= !rxd_s_q;
                    cnt_div_q <= '0;
                    cnt_bit_q <= '0;
                end else cnt_div_q <= cnt_div_q + 1'b1;
                DATA: if (cnt_div_q == div_lim) begin
                    shift_q   <= shift_d;
                    cnt_bit_q <= cnt_bit_q + 1'b1;
                    cnt_div_q <= '0;
                    if (cnt_bit_q == 4'd7) state_q <= STOP;
                end else cnt_div_q <= cnt_div_q + 1'b1;
                STOP: if (cnt_div_q == div_lim) begin
                    // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    cnt_div_q <= '0;
                    if (rxd_s_q) begin
                        data_q      <= shift_q;
                        new_data_q  <= 1'b1;
                        frame_err_q <= 1'b0;
                        if (new_data_q && !check_rxd_i) overrun_q <= 1'b1;
                    end else frame_err_q <= 1'b1;
                end else cnt_div_q <= cnt_div_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign data_o      = data_q;
    assign new_data_o  = new_data_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames at reduced dividers against hand-computed results
module tb_uart_rx_byte;
    logic       clk = 1'b0;
    logic       rst, rxd, baud, ack;
    logic [7:0] data;
    logic       new_data, frame_err, overrun, busy;
    int         n_chk = 0, n_pass = 0;

    uart_rx_byte #(.T_DIV_BIT(4), .T_DIV_0(15), .T_DIV_HALF_0(7), .T_DIV_1(7), .T_DIV_HALF_1(3)) dut (
        .clk(clk), .rst(rst), .uart_rxd_n_i(rxd), .baudrate_i(baud), .check_rxd_i(ack),
        .data_o(data), .new_data_o(new_data), .frame_err_o(frame_err), .overrun_o(overrun), .busy_o(busy)
    );

    always #5 clk = !clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int per);
        rxd = v;
        idle(per);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stp, input int per);
        hold(1'b0, per);
        for (int i = 0; i < 8; i++) hold(b[i], per);
        hold(stp, per);
        rxd = 1'b1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; baud = 1'b0; ack = 1'b0;
        idle(3);
        chk("rst_data", data, 8'h00);
        chk("rst_new", {7'd0, new_data}, 8'd0);
        chk("rst_ferr", {7'd0, frame_err}, 8'd0);
        chk("rst_ovr", {7'd0, overrun}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b0;
        idle(4);
        // 0xC5 at 16 clk/bit; new_data must rise exactly 155 edges after the pin falls
        fork
            send_frame(8'hC5, 1'b1, 16);
            begin
                idle(154);
                chk("lat_pre", {7'd0, new_data}, 8'd0);
                idle(1);
                chk("lat", {7'd0, new_data}, 8'd1);
            end
        join
        chk("c5_data", data, 8'hC5);
        chk("c5_ferr", {7'd0, frame_err}, 8'd0);
        chk("c5_busy", {7'd0, busy}, 8'd0);
        pulse_ack();
        chk("c5_ack", {7'd0, new_data}, 8'd0);
        idle(10);
        send_frame(8'h3C, 1'b0, 16);
        chk("bad_ferr", {7'd0, frame_err}, 8'd1);
        chk("bad_new", {7'd0, new_data}, 8'd0);
        chk("bad_data", data, 8'hC5);
        idle(10);
        send_frame(8'h55, 1'b1, 16);
        chk("55_ferr", {7'd0, frame_err}, 8'd0);
        chk("55_data", data, 8'h55);
        chk("55_new", {7'd0, new_data}, 8'd1);
        pulse_ack();
        idle(10);
        baud = 1'b1;
        fork
            send_frame(8'hA3, 1'b1, 8);
            begin
                idle(30);
                baud = 1'b0;
            end
        join
        chk("a3_data", data, 8'hA3);
        chk("a3_new", {7'd0, new_data}, 8'd1);
        idle(10);
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        chk("gl_busy_on", {7'd0, busy}, 8'd1);
        idle(6);
        chk("gl_busy_hold", {7'd0, busy}, 8'd1);
        idle(1);
        chk("gl_busy_off", {7'd0, busy}, 8'd0);
        chk("gl_new", {7'd0, new_data}, 8'd1);
        chk("gl_data", data, 8'hA3);
        pulse_ack();
        chk("a3_ack", {7'd0, new_data}, 8'd0);
        idle(10);
        send_frame(8'h11, 1'b1, 16);
        chk("b2b_first", data, 8'h11);
        chk("b2b_ovr0", {7'd0, overrun}, 8'd0);
        send_frame(8'h22, 1'b1, 16);
        chk("b2b_data", data, 8'h22);
        chk("b2b_new", {7'd0, new_data}, 8'd1);
        chk("b2b_ovr", {7'd0, overrun}, 8'd1);
        pulse_ack();
        chk("b2b_ack_new", {7'd0, new_data}, 8'd0);
        chk("b2b_ack_ovr", {7'd0, overrun}, 8'd0);
        idle(10);
        // upper nibble of 0xF5 is all ones, so the line stays idle-high after the abort
        fork
            send_frame(8'hF5, 1'b1, 16);
            begin
                idle(87);
                chk("mid_busy", {7'd0, busy}, 8'd1);
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                chk("mr_data", data, 8'h00);
                chk("mr_new", {7'd0, new_data}, 8'd0);
                chk("mr_ferr", {7'd0, frame_err}, 8'd0);
                chk("mr_ovr", {7'd0, overrun}, 8'd0);
                chk("mr_busy", {7'd0, busy}, 8'd0);
            end
        join
        chk("mr_no_byte", {7'd0, new_data}, 8'd0);
        idle(10);
        send_frame(8'h5A, 1'b1, 16);
        chk("5a_data", data, 8'h5A);
        chk("5a_new", {7'd0, new_data}, 8'd1);
        chk("5a_ferr", {7'd0, frame_err}, 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
